// File: rtl/sdram_tune_pkg.sv
// Shared definitions for the SDRAM phase auto-tuner.
// Holds the top FSM state encoding, the phase index width, the PLL
// direction encodings and the window-centre helper.
package sdram_tune_pkg;
  localparam int PHASE_W = 8;
  localparam logic DIR_ADV = 1'b1;
  localparam logic DIR_RET = 1'b0;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETTLE, ST_DWELL, ST_RECORD, ST_STEP, ST_SEEK, ST_DONE
  } tune_state_e;

  // Centre of the best window. A 9-bit sum keeps the carry visible. The
  // result always fits in 8 bits because start+len never exceeds C_steps.
  function automatic phase_t centre(phase_t s, phase_t l);
    logic [PHASE_W:0] t;
    t = {1'b0, s} + {1'b0, (l >> 1)};
    return (l == '0) ? '0 : t[PHASE_W-1:0];
  endfunction
endpackage

// File: rtl/sdram_phase_autotune_if.sv
// Bus between the auto-tuner and its surroundings.
// The slave modport is the tuner side:
//   - Inputs: start, pass_pulse, fail_pulse.
//   - Outputs: PLL dynamic-phase controls, tester reset and sweep results.
// The master modport is the driving side.
interface sdram_phase_autotune_if;
  import sdram_tune_pkg::*;
  logic   start, pass_pulse, fail_pulse;
  logic   phasedir, phasestep, phaseloadreg, tester_rst_n;
  phase_t phase, best_start, best_len;
  logic   busy, done, found;

  modport slave (
    input  start, pass_pulse, fail_pulse,
    output phasedir, phasestep, phaseloadreg, tester_rst_n,
           phase, best_start, best_len, busy, done, found
  );
  modport master (
    output start, pass_pulse, fail_pulse,
    input  phasedir, phasestep, phaseloadreg, tester_rst_n,
           phase, best_start, best_len, busy, done, found
  );
endinterface

// File: rtl/pll_phase_stepper.sv
// Generates one PLL dynamic phase step.
// Sequence after req_i is accepted in idle:
//   - 1 cycle in which phasedir is set up.
//   - C_pulse_cycles cycles with phasestep high.
//   - C_pulse_cycles cycles with phasestep low.
// After the low gap it emits a one-cycle ack_o.
// fall_o flags the cycle whose clock edge drops phasestep. The owner of
// the phase index updates it on that same edge.
// Ports: clk, rst_n (sync, active low), req_i, dir_i, phasedir_o,
//        phasestep_o, fall_o, ack_o.
module pll_phase_stepper
  import sdram_tune_pkg::*;
#(
  parameter int C_pulse_cycles = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic dir_i,
  output logic phasedir_o,
  output logic phasestep_o,
  output logic fall_o,
  output logic ack_o
);
  localparam int CW = $clog2(C_pulse_cycles + 1);
  typedef enum logic [1:0] {SP_IDLE, SP_DIR, SP_HIGH, SP_LOW} sp_state_e;

  sp_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dir_q, dir_d, step_q, step_d, ack_q, ack_d;
  logic            last;

  assign last = (cnt_q == CW'(C_pulse_cycles - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SP_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    step_d  = step_q;
    ack_d   = 1'b0;
    fall_o  = 1'b0;
    unique case (state_q)
      SP_IDLE: if (req_i) begin
        dir_d   = dir_i;
        state_d = SP_DIR;
      end
      SP_DIR: begin
        step_d  = 1'b1;
        cnt_d   = '0;
        state_d = SP_HIGH;
      end
      SP_HIGH: if (last) begin
        step_d  = 1'b0;
        cnt_d   = '0;
        fall_o  = 1'b1;
        state_d = SP_LOW;
      end else cnt_d = cnt_q + 1'b1;
      SP_LOW: if (last) begin
        ack_d   = 1'b1;
        state_d = SP_IDLE;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = SP_IDLE;
    endcase
  end

  assign phasedir_o  = dir_q;
  assign phasestep_o = step_q;
  assign ack_o       = ack_q;
endmodule

// File: rtl/sdram_phase_autotune.sv
// SDRAM chip-clock phase auto-tuner.
// Sweeps the PLL phase over C_steps positions. At each position it
// resets the memory tester and classifies the position pass/fail. It then
// steps back to the centre of the longest contiguous passing window.
// Ports: clk, rst_n (sync, active low), bus (sdram_phase_autotune_if.slave).
module sdram_phase_autotune
  import sdram_tune_pkg::*;
#(
  parameter int C_steps          = 64,
  parameter int C_pulse_cycles   = 16,
  parameter int C_settle_cycles  = 4096,
  parameter int C_dwell_passes   = 4,
  parameter int C_timeout_cycles = 2**24
) (
  input  logic clk,
  input  logic rst_n,
  sdram_phase_autotune_if.slave bus
);
  localparam int CNT_MAX = (C_settle_cycles > C_timeout_cycles) ? C_settle_cycles : C_timeout_cycles;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(C_dwell_passes + 1);

  tune_state_e      state_q, state_d;
  phase_t           phase_q, phase_d, bstart_q, bstart_d, blen_q, blen_d;
  phase_t           rstart_q, rstart_d, rlen_q, rlen_d, target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic good_q, good_d, busy_q, busy_d, done_q, done_d, found_q, found_d;
  logic trst_q, trst_d, req_q, req_d, sdir_q, sdir_d;
  logic step_fall, step_ack, pdir;

  pll_phase_stepper #(.C_pulse_cycles(C_pulse_cycles)) u_step (
    .clk(clk), .rst_n(rst_n), .req_i(req_q), .dir_i(sdir_q),
    .phasedir_o(pdir), .phasestep_o(bus.phasestep),
    .fall_o(step_fall), .ack_o(step_ack)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0; bstart_q <= '0; blen_q <= '0;
      rstart_q <= '0; rlen_q <= '0; target_q <= '0;
      cnt_q <= '0; pcnt_q <= '0; good_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; found_q <= 1'b0;
      trst_q <= 1'b1; req_q <= 1'b0; sdir_q <= DIR_RET;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d; bstart_q <= bstart_d; blen_q <= blen_d;
      rstart_q <= rstart_d; rlen_q <= rlen_d; target_q <= target_d;
      cnt_q <= cnt_d; pcnt_q <= pcnt_d; good_q <= good_d;
      busy_q <= busy_d; done_q <= done_d; found_q <= found_d;
      trst_q <= trst_d; req_q <= req_d; sdir_q <= sdir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q; bstart_d = bstart_q; blen_d = blen_q;
    rstart_d = rstart_q; rlen_d = rlen_q; target_d = target_q;
    cnt_d = cnt_q; pcnt_d = pcnt_q; good_d = good_q;
    busy_d = busy_q; done_d = done_q; found_d = found_q;
    trst_d = trst_q; req_d = 1'b0; sdir_d = sdir_q;

    // The index moves on the same edge that drops phasestep.
    if (step_fall) phase_d = pdir ? phase_q + 1'b1 : phase_q - 1'b1;

    unique case (state_q)
      ST_IDLE, ST_DONE: if (bus.start) begin
        // Whatever phase the PLL sits at now becomes index 0.
        busy_d = 1'b1; done_d = 1'b0; found_d = 1'b0;
        phase_d = '0; bstart_d = '0; blen_d = '0; rstart_d = '0; rlen_d = '0;
        trst_d = 1'b0; cnt_d = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: if (cnt_q == CNT_W'(C_settle_cycles - 1)) begin
        trst_d = 1'b1; cnt_d = '0; pcnt_d = '0;
        state_d = ST_DWELL;
      end else cnt_d = cnt_q + 1'b1;
      ST_DWELL: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.fail_pulse) begin
          good_d = 1'b0; state_d = ST_RECORD;
        end else if (bus.pass_pulse) begin
          cnt_d = '0;
          if (pcnt_q == PW'(C_dwell_passes - 1)) begin
            good_d = 1'b1; state_d = ST_RECORD;
          end else pcnt_d = pcnt_q + 1'b1;
        end else if (cnt_q == CNT_W'(C_timeout_cycles - 1)) begin
          good_d = 1'b0; state_d = ST_RECORD;
        end
      end
      ST_RECORD: begin
        if (good_q) begin
          if (rlen_q == '0) rstart_d = phase_q;
          rlen_d = rlen_q + 1'b1;
        end else rlen_d = '0;
        // Strict compare keeps the earliest of equal-length runs.
        if (rlen_d > blen_q) begin
          bstart_d = rstart_d; blen_d = rlen_d;
        end
        if (phase_q < PHASE_W'(C_steps - 1)) begin
          req_d = 1'b1; sdir_d = DIR_ADV; state_d = ST_STEP;
        end else begin
          target_d = centre(bstart_d, blen_d);
          state_d  = ST_SEEK;
        end
      end
      ST_STEP: if (step_ack) begin
        if (sdir_q == DIR_ADV) begin
          trst_d = 1'b0; cnt_d = '0; state_d = ST_SETTLE;
        end else state_d = ST_SEEK;
      end
      ST_SEEK: if (phase_q == target_q) begin
        done_d = 1'b1; busy_d = 1'b0; found_d = (blen_q != '0);
        state_d = ST_DONE;
      end else begin
        req_d = 1'b1; sdir_d = DIR_RET; state_d = ST_STEP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.phasedir     = pdir;
  assign bus.phaseloadreg = 1'b0;
  assign bus.tester_rst_n = trst_q;
  assign bus.phase        = phase_q;
  assign bus.best_start   = bstart_q;
  assign bus.best_len     = blen_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.found        = found_q;
endmodule

// File: tb/tb_sdram_phase_autotune.sv
// Directed bench for sdram_phase_autotune with 8 positions and short timings.
// A tester model answers each tester-reset release according to a per-position
// mode table. A monitor counts pulses and checks the pulse, gap and settle timing.
module tb_sdram_phase_autotune;
  localparam int P = 4, S = 12, T = 100, N = 8;
  localparam int M_PASS = 0, M_FAIL = 1, M_BOTH = 2, M_NONE = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_phase_autotune_if bus ();

  sdram_phase_autotune #(
    .C_steps(N), .C_pulse_cycles(P), .C_settle_cycles(S),
    .C_dwell_passes(4), .C_timeout_cycles(T)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0, bad = 0;
  int mode [0:7];
  int adv_cnt = 0, ret_cnt = 0;
  bit mon_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Tester model: reacts when the tester comes out of reset during a sweep.
  task automatic tpulse(input logic p, input logic f);
    repeat (2) @(posedge clk);
    #1 bus.pass_pulse = p; bus.fail_pulse = f;
    @(posedge clk);
    #1 bus.pass_pulse = 1'b0; bus.fail_pulse = 1'b0;
  endtask

  initial begin
    int m, np;
    bus.pass_pulse = 1'b0; bus.fail_pulse = 1'b0;
    forever begin
      @(posedge bus.tester_rst_n);
      if (bus.busy === 1'b1) begin
        m = mode[bus.phase[2:0]];
        if (m != M_NONE) begin
          np = (m == M_PASS) ? 4 : (m == M_BOTH) ? 3 : 1;
          for (int k = 0; k < np; k++) tpulse(1'b1, 1'b0);
          if (m != M_PASS) tpulse(m == M_BOTH, 1'b1);
        end
      end
    end
  end

  // Pulse and settle timing monitor, sampled on the falling edge.
  initial begin
    bit prev_step, prev_dir, prev_trst, seen, pdir, dir_bad;
    int hi_len, lo_len, trst_low;
    prev_step = 0; prev_dir = 0; prev_trst = 1; seen = 0; pdir = 0; dir_bad = 0;
    hi_len = 0; lo_len = 0; trst_low = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_step = 0; prev_trst = 1; seen = 0; hi_len = 0; lo_len = 0; trst_low = 0;
      end else begin
        if (bus.phasestep && !prev_step) begin
          if (bus.phasedir) adv_cnt++; else ret_cnt++;
          if (mon_en && seen) chk("gap_min", 32'(lo_len >= P), 1);
          if (mon_en) chk("dir_pre", bus.phasedir, prev_dir);
          hi_len = 1; pdir = bus.phasedir; dir_bad = 0; seen = 0;
        end else if (bus.phasestep) hi_len++;
        else if (prev_step) begin
          if (mon_en) chk("pulse_hi", hi_len, P);
          lo_len = 1; seen = 1;
        end else lo_len++;
        if (bus.phasestep || (seen && lo_len <= P))
          if (bus.phasedir != pdir) dir_bad = 1;
        if (!bus.phasestep && seen && lo_len == P && mon_en) chk("dir_hold", dir_bad, 0);
        if (!bus.tester_rst_n) trst_low++;
        else if (!prev_trst) begin
          if (mon_en) chk("settle_len", trst_low, S);
          trst_low = 0;
        end
        prev_step = bus.phasestep; prev_dir = bus.phasedir; prev_trst = bus.tester_rst_n;
      end
    end
  end

  task automatic sweep(input logic [7:0] e_bs, input logic [7:0] e_bl, input logic [7:0] e_ph,
                       input logic e_found, input int e_adv, input int e_ret);
    int a0, r0, n;
    a0 = adv_cnt; r0 = ret_cnt;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk("busy_on_start", bus.busy, 1);
    chk("done_clr", bus.done, 0);
    n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk("done_timeout", 32'(n < 3000), 1);
    chk("best_start", bus.best_start, e_bs);
    chk("best_len", bus.best_len, e_bl);
    chk("final_phase", bus.phase, e_ph);
    chk("found", bus.found, e_found);
    chk("busy_done", bus.busy, 0);
    chk("adv_pulses", adv_cnt - a0, e_adv);
    chk("ret_pulses", ret_cnt - r0, e_ret);
  endtask

  initial begin
    int a0, n;
    bus.start = 1'b0;
    for (int i = 0; i < N; i++) mode[i] = M_FAIL;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_phasestep", bus.phasestep, 0);
    chk("rst_phasedir", bus.phasedir, 0);
    chk("rst_loadreg", bus.phaseloadreg, 0);
    chk("rst_trst", bus.tester_rst_n, 1);
    chk("rst_phase", bus.phase, 0);
    chk("rst_best", {bus.best_start, bus.best_len}, 0);
    chk("rst_flags", {bus.busy, bus.done, bus.found}, 0);
    #1 rst_n = 1'b1;

    // Passing window 2..5: centre 4, 3 retards from 7.
    for (int i = 0; i < N; i++) mode[i] = (i >= 2 && i <= 5) ? M_PASS : M_FAIL;
    sweep(8'd2, 8'd4, 8'd4, 1'b1, 7, 3);
    // Everything fails: back to 0.
    for (int i = 0; i < N; i++) mode[i] = M_FAIL;
    sweep(8'd0, 8'd0, 8'd0, 1'b0, 7, 7);
    // Equal runs 1..2 and 5..6: earliest wins, centre 2.
    for (int i = 0; i < N; i++) mode[i] = (i == 1 || i == 2 || i == 5 || i == 6) ? M_PASS : M_FAIL;
    sweep(8'd1, 8'd2, 8'd2, 1'b1, 7, 5);
    // 3 sees pass+fail together, 4 times out: runs 0..2 and 5..7, centre 1.
    for (int i = 0; i < N; i++) mode[i] = M_PASS;
    mode[3] = M_BOTH; mode[4] = M_NONE;
    sweep(8'd0, 8'd3, 8'd1, 1'b1, 7, 6);
    // All pass: run reaches the last position, centre 4.
    for (int i = 0; i < N; i++) mode[i] = M_PASS;
    sweep(8'd0, 8'd8, 8'd4, 1'b1, 7, 3);

    // start while busy, then reset during the fourth pulse.
    mon_en = 1'b0;
    a0 = adv_cnt;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    n = 0;
    while (adv_cnt < a0 + 2 && n < 2000) begin @(negedge clk); n++; end
    chk("wait_pulse2", 32'(n < 2000), 1);
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk("busy_start_phase", bus.phase, 1);
    chk("busy_start_busy", bus.busy, 1);
    chk("busy_start_step", bus.phasestep, 1);
    n = 0;
    while (adv_cnt < a0 + 4 && n < 2000) begin @(negedge clk); n++; end
    chk("wait_pulse4", 32'(n < 2000), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_step", bus.phasestep, 0);
    chk("mid_rst_phase", bus.phase, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_trst", bus.tester_rst_n, 1);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    mon_en = 1'b1;
    sweep(8'd0, 8'd8, 8'd4, 1'b1, 7, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
